// File: rtl/aes_spi_slave.sv
// aes_spi_slave: oversampled SPI mode-0 slave that collects an AES command frame,
// launches the attached core and serves the 128-bit result back on a read frame.
module aes_spi_slave #(
  parameter int Nk = 8,
  parameter int Nr = Nk + 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sck,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic [127:0]       aes_data,
  output logic [Nk*32-1:0]   aes_key,
  output logic               aes_enc_start,
  output logic               aes_dec_start,
  input  logic               aes_done,
  input  logic [127:0]       aes_result,
  output logic               busy,
  output logic               result_valid,
  output logic               frame_err
);

  localparam int KeyBits   = Nk * 32;
  localparam int PayBits   = 128 + KeyBits;
  localparam int FrameBits = 8 + PayBits;
  localparam int CntW      = $clog2(FrameBits + 1);

  localparam logic [CntW-1:0] CntOpc  = CntW'(8);
  localparam logic [CntW-1:0] CntFull = CntW'(FrameBits);
  localparam logic [7:0]      OpEnc   = 8'hA5;
  localparam logic [7:0]      OpDec   = 8'h5A;
  localparam logic [7:0]      OpRd    = 8'h3C;

  if (!(Nk == 4 || Nk == 6 || Nk == 8) || Nr != Nk + 6) begin : g_param_check
    $error("aes_spi_slave: Nk must be 4, 6 or 8 and Nr must equal Nk+6");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RX_CMD     = 3'd1,
    RX_PAYLOAD = 3'd2,
    TX_RESULT  = 3'd3,
    LAUNCH     = 3'd4,
    WAIT_CORE  = 3'd5
  } state_t;

  logic [2:0]         sck_sync_r;
  logic [2:0]         cs_sync_r;
  logic [1:0]         mosi_sync_r;
  logic               sck_rise_r;
  logic               sck_fall_r;
  logic               cs_rise_r;
  logic               cs_fall_r;
  logic               mosi_bit_r;
  logic [CntW-1:0]    bit_cnt_r;
  logic [PayBits-1:0] rx_shift_r;
  logic [7:0]         opcode_r;
  logic [127:0]       result_r;
  logic [127:0]       tx_shift_r;
  state_t             state_r;
  state_t             state_nx_s;
  logic               launch_s;
  logic               err_set_s;
  logic               tx_load_s;
  logic               done_s;
  logic               busy_eff_s;
  logic               res_avail_s;
  logic [127:0]       snapshot_s;

  // A completion in the same clk as a frame decision is treated as already retired
  assign done_s      = aes_done & busy;
  assign busy_eff_s  = busy & ~aes_done;
  assign res_avail_s = result_valid | done_s;

  // Snapshot loaded into the serialiser when a read frame is decoded
  always_comb begin
    snapshot_s = 128'd0;
    if (done_s) begin
      snapshot_s = aes_result;
    end else if (result_valid) begin
      snapshot_s = result_r;
    end else begin
      snapshot_s = 128'd0;
    end
  end

  // Pin synchronisers with registered edge detection (cs_n idles high)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_r  <= 3'b000;
      cs_sync_r   <= 3'b111;
      mosi_sync_r <= 2'b00;
      sck_rise_r  <= 1'b0;
      sck_fall_r  <= 1'b0;
      cs_rise_r   <= 1'b0;
      cs_fall_r   <= 1'b0;
      mosi_bit_r  <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[1:0], sck};
      cs_sync_r   <= {cs_sync_r[1:0], cs_n};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
      sck_rise_r  <= sck_sync_r[1] & ~sck_sync_r[2];
      sck_fall_r  <= ~sck_sync_r[1] & sck_sync_r[2];
      cs_rise_r   <= cs_sync_r[1] & ~cs_sync_r[2];
      cs_fall_r   <= ~cs_sync_r[1] & cs_sync_r[2];
      mosi_bit_r  <= mosi_sync_r[1];
    end
  end

  // Bit counter and receive shifter; the opcode falls off the top of a full frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_r  <= {CntW{1'b0}};
      rx_shift_r <= {PayBits{1'b0}};
      opcode_r   <= 8'h00;
    end else begin
      if (cs_fall_r) begin
        bit_cnt_r <= {CntW{1'b0}};
      end else if (sck_rise_r && !cs_sync_r[2] && bit_cnt_r != CntFull) begin
        bit_cnt_r  <= bit_cnt_r + CntW'(1);
        rx_shift_r <= {rx_shift_r[PayBits-2:0], mosi_bit_r};
      end
      if (state_r == RX_CMD && bit_cnt_r == CntOpc) begin
        opcode_r <= rx_shift_r[7:0];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state and frame decisions
  always_comb begin
    state_nx_s = state_r;
    launch_s   = 1'b0;
    err_set_s  = 1'b0;
    tx_load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs_fall_r) state_nx_s = RX_CMD;
        else           state_nx_s = IDLE;
      end
      RX_CMD: begin
        if (cs_rise_r) begin
          state_nx_s = IDLE;
          err_set_s  = 1'b1;
        end else if (bit_cnt_r == CntOpc) begin
          case (rx_shift_r[7:0])
            OpEnc, OpDec: state_nx_s = RX_PAYLOAD;
            OpRd: begin
              state_nx_s = TX_RESULT;
              tx_load_s  = 1'b1;
              err_set_s  = ~res_avail_s;
            end
            default: err_set_s = 1'b1;
          endcase
        end else begin
          state_nx_s = RX_CMD;
        end
      end
      RX_PAYLOAD: begin
        if (cs_rise_r) begin
          if (bit_cnt_r == CntFull && !busy_eff_s) begin
            state_nx_s = LAUNCH;
            launch_s   = 1'b1;
          end else begin
            state_nx_s = IDLE;
            err_set_s  = 1'b1;
          end
        end else begin
          state_nx_s = RX_PAYLOAD;
        end
      end
      TX_RESULT: begin
        if (cs_rise_r) state_nx_s = IDLE;
        else           state_nx_s = TX_RESULT;
      end
      LAUNCH: state_nx_s = WAIT_CORE;
      WAIT_CORE: begin
        // A new frame may start while the core is still running
        if (cs_fall_r)     state_nx_s = RX_CMD;
        else if (aes_done) state_nx_s = IDLE;
        else               state_nx_s = WAIT_CORE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Core launch, result capture and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aes_data      <= 128'd0;
      aes_key       <= {KeyBits{1'b0}};
      aes_enc_start <= 1'b0;
      aes_dec_start <= 1'b0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      result_r      <= 128'd0;
      frame_err     <= 1'b0;
    end else begin
      aes_enc_start <= launch_s & (opcode_r != OpDec);
      aes_dec_start <= launch_s & (opcode_r == OpDec);
      if (done_s) begin
        result_r     <= aes_result;
        busy         <= 1'b0;
        result_valid <= 1'b1;
      end
      if (launch_s) begin
        aes_data     <= rx_shift_r[PayBits-1 -: 128];
        aes_key      <= rx_shift_r[KeyBits-1:0];
        busy         <= 1'b1;
        result_valid <= 1'b0;
      end
      if (cs_fall_r) begin
        frame_err <= 1'b0;
      end else if (err_set_s) begin
        frame_err <= 1'b1;
      end
    end
  end

  // Result serialiser: one bit per sck fall, zero-filled after the last bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift_r <= 128'd0;
      miso       <= 1'b0;
    end else if (tx_load_s) begin
      tx_shift_r <= snapshot_s;
      miso       <= 1'b0;
    end else if (state_r == TX_RESULT) begin
      if (sck_fall_r) begin
        miso       <= tx_shift_r[127];
        tx_shift_r <= {tx_shift_r[126:0], 1'b0};
      end
    end else begin
      miso <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_spi_slave.sv
// Directed + randomized bench for aes_spi_slave: SPI master driver, a simple core
// model and a frame-level reference model of the expected slave behaviour.
module tb_aes_spi_slave;

  localparam int NK    = 8;
  localparam int KB    = NK * 32;
  localparam int FRAME = 8 + 128 + KB;
  localparam int HALF  = 5;
  localparam logic [255:0] KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic          clk = 1'b0;
  logic          rst;
  logic          sck;
  logic          cs_n;
  logic          mosi;
  logic          miso;
  logic [127:0]  aes_data;
  logic [KB-1:0] aes_key;
  logic          aes_enc_start;
  logic          aes_dec_start;
  logic          aes_done;
  logic [127:0]  aes_result;
  logic          busy;
  logic          result_valid;
  logic          frame_err;

  aes_spi_slave #(.Nk(NK)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .aes_data(aes_data), .aes_key(aes_key),
    .aes_enc_start(aes_enc_start), .aes_dec_start(aes_dec_start),
    .aes_done(aes_done), .aes_result(aes_result),
    .busy(busy), .result_valid(result_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  bit tx_q[$];
  bit rx_q[$];
  logic err_at_start;
  int rise_cyc;

  // core model bookkeeping
  int enc_cnt = 0, dec_cnt = 0, done_cnt = 0, start_cyc = 0;
  int core_lat = 20, core_left = 0;
  logic [127:0] core_res, cap_data;
  logic [255:0] cap_key;

  // reference model state
  logic m_busy, m_valid, m_dec;
  logic [127:0] m_result, m_data;
  logic [255:0] m_key;
  logic exp_launch, exp_err, exp_dec;
  logic [127:0] exp_rd;

  function automatic logic [127:0] core_fn(input logic enc, input logic [127:0] d,
                                           input logic [255:0] k);
    if (enc && d == PT && k == KEY) return CT;
    if (!enc && d == CT && k == KEY) return PT;
    return d ^ k[255:128] ^ k[127:0];
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core model: latches inputs on a start pulse, answers core_lat clk later
  initial begin
    aes_done = 1'b0;
    aes_result = 128'd0;
    forever begin
      @(negedge clk);
      aes_done = 1'b0;
      if (aes_enc_start || aes_dec_start) begin
        if (aes_enc_start) enc_cnt++;
        if (aes_dec_start) dec_cnt++;
        start_cyc = cyc;
        cap_data  = aes_data;
        cap_key   = aes_key;
        core_res  = core_fn(aes_enc_start, aes_data, aes_key);
        core_left = core_lat;
      end else if (core_left > 0) begin
        core_left--;
        if (core_left == 0) begin
          aes_done   = 1'b1;
          aes_result = core_res;
          done_cnt++;
        end
      end
    end
  end

  task automatic build(input logic [7:0] op, input logic [127:0] blk, input logic [255:0] key);
    tx_q.delete();
    for (int i = 7; i >= 0; i--) tx_q.push_back(op[i]);
    for (int i = 127; i >= 0; i--) tx_q.push_back(blk[i]);
    for (int i = 255; i >= 0; i--) tx_q.push_back(key[i]);
  endtask

  // Frame-level prediction from the opcode, the bit count and the slave's status
  task automatic predict(input int nbits);
    logic [7:0] op;
    op = 8'h00;
    for (int i = 0; i < 8 && i < nbits; i++) op = {op[6:0], tx_q[i]};
    exp_launch = 1'b0;
    exp_err    = 1'b0;
    exp_dec    = 1'b0;
    exp_rd     = 128'd0;
    if (nbits < 8) begin
      exp_err = 1'b1;
    end else if (op == 8'hA5 || op == 8'h5A) begin
      if (nbits != FRAME || m_busy) begin
        exp_err = 1'b1;
      end else begin
        exp_launch = 1'b1;
        exp_dec    = (op == 8'h5A);
        for (int i = 0; i < 128; i++) m_data[127-i] = tx_q[8+i];
        for (int i = 0; i < KB; i++) m_key[KB-1-i] = tx_q[136+i];
        m_dec   = exp_dec;
        m_busy  = 1'b1;
        m_valid = 1'b0;
      end
    end else if (op == 8'h3C) begin
      exp_err = ~m_valid;
      exp_rd  = m_valid ? m_result : 128'd0;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic spi_frame(input int nbits, input bit keep_cs);
    rx_q.delete();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < tx_q.size()) ? tx_q[i] : 1'b0;
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      rx_q.push_back(miso);
      if (i == 0) err_at_start = frame_err;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    if (!keep_cs) begin
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      rise_cyc = cyc;
      mosi = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic write_frame(input string tag, input logic [7:0] op, input logic [127:0] blk,
                             input logic [255:0] key, input int nbits);
    int e0, d0;
    build(op, blk, key);
    predict(nbits);
    e0 = enc_cnt;
    d0 = dec_cnt;
    spi_frame(nbits, 1'b0);
    check({tag, ":err_clear"}, 256'(err_at_start), 256'd0);
    check({tag, ":frame_err"}, 256'(frame_err), 256'(exp_err));
    check({tag, ":starts"}, 256'({enc_cnt - e0, dec_cnt - d0}),
          256'({32'(exp_launch && !exp_dec), 32'(exp_launch && exp_dec)}));
    check({tag, ":aes_data"}, 256'(aes_data), 256'(m_data));
    check({tag, ":aes_key"}, 256'(aes_key), m_key);
    if (exp_launch) begin
      check({tag, ":latency"}, 256'(start_cyc - rise_cyc), 256'd4);
      check({tag, ":core_in"}, {cap_data, cap_key[127:0]}, {m_data, m_key[127:0]});
      check({tag, ":busy"}, 256'({busy, result_valid}), 256'(2'b10));
    end
  endtask

  task automatic read_frame(input string tag);
    logic [127:0] got;
    logic outside;
    build(8'h3C, 128'd0, 256'd0);
    predict(144);
    spi_frame(144, 1'b0);
    outside = 1'b0;
    for (int i = 0; i < 8; i++) outside |= rx_q[i];
    for (int i = 0; i < 128; i++) got[127-i] = rx_q[8+i];
    for (int i = 136; i < 144; i++) outside |= rx_q[i];
    check({tag, ":err_clear"}, 256'(err_at_start), 256'd0);
    check({tag, ":miso_data"}, 256'(got), 256'(exp_rd));
    check({tag, ":miso_idle"}, 256'(outside), 256'd0);
    check({tag, ":frame_err"}, 256'(frame_err), 256'(exp_err));
    check({tag, ":rv_kept"}, 256'(result_valid), 256'(m_valid));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":done_seen"}, 256'(n < budget), 256'd1);
    repeat (2) @(negedge clk);
    m_busy   = 1'b0;
    m_valid  = 1'b1;
    m_result = core_fn(!m_dec, m_data, m_key);
    check({tag, ":status"}, 256'({busy, result_valid}), 256'(2'b01));
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_valid = 1'b0; m_dec = 1'b0;
    m_result = 128'd0; m_data = 128'd0; m_key = 256'd0;
  endtask

  initial begin
    logic [127:0] rblk;
    logic [255:0] rkey;
    logic [7:0] rop;
    rst = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("reset:outs", 256'({miso, aes_enc_start, aes_dec_start, busy, result_valid, frame_err}), 256'd0);
    check("reset:data", 256'(aes_data), 256'd0);
    check("reset:key", 256'(aes_key), 256'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    write_frame("enc", 8'hA5, PT, KEY, FRAME);
    wait_done("enc", 200);
    read_frame("rd_ct");

    write_frame("dec", 8'h5A, CT, KEY, FRAME);
    wait_done("dec", 200);
    read_frame("rd_pt");

    write_frame("short", 8'hA5, PT, KEY, 200);
    read_frame("rd_after_short");

    core_lat = 6000;
    write_frame("coll1", 8'hA5, PT, KEY, FRAME);
    write_frame("coll2", 8'hA5, CT, ~KEY, FRAME);
    wait_done("coll", 8000);
    core_lat = 20;

    write_frame("badop", 8'h00, PT, KEY, FRAME);
    check("badop:miso", 256'(rx_q.sum() with (int'(item))), 256'd0);

    build(8'hA5, CT, KEY);
    spi_frame(108, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midrst:outs", 256'({miso, aes_enc_start, aes_dec_start, busy, result_valid, frame_err}), 256'd0);
    check("midrst:data", 256'(aes_data), 256'd0);
    check("midrst:key", 256'(aes_key), 256'd0);
    cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    read_frame("rd_empty");
    write_frame("enc_fresh", 8'hA5, PT, KEY, FRAME);
    wait_done("enc_fresh", 200);
    read_frame("rd_fresh");

    for (int it = 0; it < 3; it++) begin
      rop  = ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'h5A;
      rblk = {$urandom, $urandom, $urandom, $urandom};
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      write_frame("rnd", rop, rblk, rkey, FRAME);
      wait_done("rnd", 200);
      read_frame("rnd_rd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
